// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package reg_dump_pkg;

    localparam int NUM_REGS_DEF = 4;
    localparam int DATA_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SEND,
        ST_CSUM,
        ST_FIN
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_dump.sv
// Streams every register-file entry out over a valid/ready port.
// Optional trailing XOR checksum beat: define REG_DUMP_CHECKSUM_EN.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    localparam int IW      = idx_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    output logic [IW-1:0]     RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              w_valid;
    logic              w_xfer;
    logic              w_last;

    assign w_xfer   = w_valid & out_ready;
    assign w_last   = (r_idx == LAST);
    assign RdAddr   = r_idx;
    assign out_data = r_out_data;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = ST_ADDR;
            ST_ADDR: w_next = ST_SEND;
            ST_SEND: begin
                if (w_xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    w_next = w_last ? ST_CSUM : ST_ADDR;
`else
                    w_next = w_last ? ST_FIN : ST_ADDR;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: if (w_xfer) w_next = ST_FIN;
`endif
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid = (r_state == ST_SEND);
`ifdef REG_DUMP_CHECKSUM_EN
        w_valid = w_valid | (r_state == ST_CSUM);
`endif
        out_valid = w_valid;
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_FIN);
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    // Running XOR of the snapshots taken so far in this dump.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_csum <= '0;
        end else if (r_state == ST_ADDR) begin
            r_csum <= r_csum ^ RdData;
        end
    end
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (start) r_idx <= '0;
                ST_ADDR: r_out_data <= RdData;
                ST_SEND: begin
                    if (w_xfer && !w_last) begin
                        r_idx <= r_idx + IW'(1);
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    if (w_xfer && w_last) begin
                        r_out_data <= r_csum;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: directed scenarios plus random back-pressure.
// Expected beats come from a register-file array snapshot taken at start.
module tb_reg_dump;

    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [1:0]    RdAddr;
    logic [DW-1:0] RdData;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];
    logic          rdy_auto = 1'b0;
    logic          rnd_rdy  = 1'b1;
    logic          man_rdy  = 1'b1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [DW-1:0] expq [$];

    assign RdData    = regs[RdAddr];
    assign out_ready = rdy_auto ? rnd_rdy : man_rdy;

    reg_dump #(.NUM_REGS(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer, checks hold rules
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_done  = 1'b0;
    logic [DW-1:0] p_data  = '0;

    always @(negedge clk) begin
        if (Reset) begin
            if (done) begin
                done_cnt++;
                check("done_one_cycle", {31'd0, p_done}, 32'd0);
            end
            if (p_valid && !p_ready) begin
                check("valid_held", {31'd0, out_valid}, 32'd1);
                check("data_held", {24'd0, out_data}, {24'd0, p_data});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [DW-1:0] e;
                    e = expq.pop_front();
                    check("beat", {24'd0, out_data}, {24'd0, e});
                end
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_done  = done;
            p_data  = out_data;
        end else begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_done  = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NR; i++) begin
            expq.push_back(regs[i]);
            x = x ^ regs[i];
        end
`ifdef REG_DUMP_CHECKSUM_EN
        expq.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_dump();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) return;
            tick();
        end
        check({nm, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            tick();
        end
        check({nm, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int d0;
        logic [DW-1:0] csum;
        int nb;

        Reset   = 1'b0;
        start   = 1'b0;
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
`ifdef REG_DUMP_CHECKSUM_EN
        nb = NR + 1;
`else
        nb = NR;
`endif
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_addr", {30'd0, RdAddr}, 32'd0);
        Reset = 1'b1;
        tick();

        // Full-rate dump: beats on alternate cycles, then one done
        d0 = done_cnt;
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            logic ev, ed, eb;
            tick();
            ev = (k % 2 == 1 && k <= 2 * NR - 1) || (nb > NR && k == 2 * NR);
            ed = (k == 2 * NR + nb - NR);
            eb = (k <= 2 * NR + nb - NR);
            check($sformatf("tl_valid_k%0d", k), {31'd0, out_valid}, {31'd0, ev});
            check($sformatf("tl_done_k%0d", k), {31'd0, done}, {31'd0, ed});
            check($sformatf("tl_busy_k%0d", k), {31'd0, busy}, {31'd0, eb});
        end
        check("tl_drained", expq.size(), 32'd0);
        check("tl_done_cnt", done_cnt, d0 + 1);

        // Stall on beat 1, and rewrite reg 2 while beat 2 is stalled
        man_rdy = 1'b0;
        d0 = done_cnt;
        pulse_start();
        for (int b = 0; b < NR; b++) begin
            wait_valid("stall");
            if (b == 1) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", {24'd0, out_data}, 32'h22);
                    check("stall_idx", {30'd0, RdAddr}, 32'd1);
                end
            end
            if (b == 2) begin
                regs[2] = 8'h99;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("snap_data", {24'd0, out_data}, 32'h33);
                end
            end
            man_rdy = 1'b1;
            tick();
            man_rdy = 1'b0;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        wait_valid("csum");
        check("csum_beat", {24'd0, out_data}, 32'h44);
`endif
        man_rdy = 1'b1;
        wait_idle("stall");
        regs[2] = 8'h33;
        check("stall_drained", expq.size(), 32'd0);
        check("stall_done_cnt", done_cnt, d0 + 1);

        // Start during beat 1 is ignored
        d0 = done_cnt;
        pulse_start();
        wait_valid("ign0");
        tick();
        wait_valid("ign1");
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ign");
        for (int i = 0; i < 4; i++) tick();
        check("ign_busy", {31'd0, busy}, 32'd0);
        check("ign_drained", expq.size(), 32'd0);
        check("ign_done_cnt", done_cnt, d0 + 1);

        // Reset during beat 2 aborts without done
        pulse_start();
        wait_valid("rst0");
        tick();
        wait_valid("rst1");
        tick();
        wait_valid("rst2");
        Reset = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_addr", {30'd0, RdAddr}, 32'd0);
        check("abort_data", {24'd0, out_data}, 32'd0);
        expq.delete();
        d0 = done_cnt;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        tick();
        check("abort_no_done", done_cnt, d0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        pulse_start();
        wait_valid("restart");
        check("restart_first", {24'd0, out_data}, 32'h11);
        wait_idle("restart");
        check("restart_done_cnt", done_cnt, d0 + 1);

        // Random register contents under random back-pressure
        rdy_auto = 1'b1;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
            d0 = done_cnt;
            pulse_start();
            wait_idle("rnd");
            tick();
            check("rnd_drained", expq.size(), 32'd0);
            check("rnd_done_cnt", done_cnt, d0 + 1);
        end
        rdy_auto = 1'b0;
        csum = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
